// File: rtl/cla_addsub_pipe.sv
// ============================================================================
// cla_addsub_pipe : pipelined carry-lookahead add/sub, one lookahead group per stage
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cla_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic             cin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NSTG = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || BLOCK < 1 || BLOCK > WIDTH) begin : g_param_check
    $error("cla_addsub_pipe: WIDTH must be a positive multiple of BLOCK");
  end

  logic [NSTG-1:0]            vld_q;
  logic [NSTG-1:0]            adv;
  logic [NSTG-1:0]            vin;
  logic [NSTG-1:0]            ld;
  logic [NSTG-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic [NSTG-1:0][WIDTH-1:0] a_d, b_d, sum_d;
  logic [NSTG-1:0]            cy_q, zr_q, cy_d, zr_d;
  logic                       cm_q, cm_d;

  // Backward advance chain: a stage moves when the one after it is empty or moving.
  always_comb begin
    logic nxt;
    int   km1;
    adv = '0;
    vin = '0;
    nxt = ready_i;
    for (int k = NSTG - 1; k >= 0; k--) begin
      adv[k] = nxt | ~vld_q[k];
      nxt    = adv[k];
    end
    for (int k = 0; k < NSTG; k++) begin
      km1    = (k == 0) ? 0 : k - 1;
      vin[k] = (k == 0) ? valid_i : vld_q[km1];
    end
    ld = adv & vin;
  end

  assign ready_o = adv[0];

  always_comb begin
    logic [WIDTH-1:0] ia, ib, isum;
    logic             ic, iz, t, pp;
    logic [BLOCK-1:0] p, g, s;
    logic [BLOCK:0]   c;
    int               km1;
    a_d   = '0;
    b_d   = '0;
    sum_d = '0;
    cy_d  = '0;
    zr_d  = '0;
    cm_d  = 1'b0;
    for (int k = 0; k < NSTG; k++) begin
      km1 = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        ia   = a_i;
        ib   = op_i[0] ? ~b_i : b_i;
        ic   = op_i[1] ? cin_i : op_i[0];
        iz   = 1'b1;
        isum = '0;
      end else begin
        ia   = a_q[km1];
        ib   = b_q[km1];
        ic   = cy_q[km1];
        iz   = zr_q[km1];
        isum = sum_q[km1];
      end
      p = ia[k*BLOCK +: BLOCK] ^ ib[k*BLOCK +: BLOCK];
      g = ia[k*BLOCK +: BLOCK] & ib[k*BLOCK +: BLOCK];
      // Each carry is a flat sum of products over the group, not a ripple.
      c    = '0;
      c[0] = ic;
      for (int i = 0; i < BLOCK; i++) begin
        t  = g[i];
        pp = p[i];
        for (int j = i - 1; j >= 0; j--) begin
          t  = t | (pp & g[j]);
          pp = pp & p[j];
        end
        c[i+1] = t | (pp & ic);
      end
      s                         = p ^ c[BLOCK-1:0];
      sum_d[k]                  = isum;
      sum_d[k][k*BLOCK +: BLOCK] = s;
      a_d[k]                    = ia;
      b_d[k]                    = ib;
      cy_d[k]                   = c[BLOCK];
      zr_d[k]                   = iz & ~(|s);
      if (k == NSTG - 1) cm_d = c[BLOCK-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      cy_q  <= '0;
      zr_q  <= '0;
      cm_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (adv[k]) vld_q[k] <= vin[k];
        if (ld[k]) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          sum_q[k] <= sum_d[k];
          cy_q[k]  <= cy_d[k];
          zr_q[k]  <= zr_d[k];
        end
      end
      if (ld[NSTG-1]) cm_q <= cm_d;
    end
  end

  assign valid_o = vld_q[NSTG-1];
  assign sum_o   = sum_q[NSTG-1];
  assign carry_o = cy_q[NSTG-1];
  assign ovf_o   = cm_q ^ cy_q[NSTG-1];
  assign zero_o  = zr_q[NSTG-1];

endmodule

`default_nettype wire
